instr_issuer: RTL

Instruction-side initiator for the datapath `controller`. It fetches 16-bit instructions from a synchronous instruction memory and decodes the opcode, ALU_op, shift_op and register/immediate fields. It drives the one-cycle `start` handshake into `controller`, then waits for `waiting` to fall and rise again before it fetches the next instruction. It sits between instruction memory and `controller`, and replaces the hand-driven start/opcode stimulus used at lab level.

---
 rtl/instr_issuer.sv | 114 +++++++++++
 1 files changed

// File: rtl/instr_issuer.sv
// Instruction-side initiator: fetches 16-bit instructions, decodes their fields and
// hands each one to the datapath controller with a one-cycle start pulse.
module instr_issuer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              waiting,
  output logic              start,
  output logic [2:0]        opcode,
  output logic [1:0]        ALU_op,
  output logic [1:0]        shift_op,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [2:0]        rm,
  output logic [7:0]        imm8,
  output logic              halted,
  output logic              err,
  output logic [7:0]        issued
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StIssue,
    StWait,
    StHalt,
    StError
  } state_e;

  localparam logic [7:0] TLast = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir_q;
  logic [7:0]        tcount_q;
  logic              busy_seen_q;
  logic              halted_q;
  logic              err_q;
  logic [7:0]        issued_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ir_q        <= 16'h0000;
      tcount_q    <= 8'd0;
      busy_seen_q <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      issued_q    <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go) begin
            pc_q    <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: state_q <= StLoad;
        StLoad: begin
          ir_q <= mem_rdata;
          if (mem_rdata[15:13] == HALT_OP) begin
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else begin
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (waiting) begin
            issued_q    <= issued_q + 8'd1;
            busy_seen_q <= 1'b0;
            tcount_q    <= 8'd0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          tcount_q <= tcount_q + 8'd1;
          if (!waiting) busy_seen_q <= 1'b1;
          // Completion needs a busy phase first; an early ready is stale.
          if (busy_seen_q && waiting) begin
            pc_q    <= pc_q + 1'b1;
            state_q <= StFetch;
          end else if (tcount_q == TLast) begin
            err_q   <= 1'b1;
            state_q <= StError;
          end
        end
        default: ; // StHalt and StError hold until reset
      endcase
    end
  end

  assign start    = (state_q == StIssue) && waiting;
  assign mem_addr = pc_q;
  assign opcode   = ir_q[15:13];
  assign ALU_op   = ir_q[12:11];
  assign rn       = ir_q[10:8];
  assign rd       = ir_q[7:5];
  assign shift_op = ir_q[4:3];
  assign rm       = ir_q[2:0];
  assign imm8     = ir_q[7:0];
  assign halted   = halted_q;
  assign err      = err_q;
  assign issued   = issued_q;

endmodule
